// File: rtl/alu_cmd_sequencer_if.sv
// Command / ALU / response signal bundle for alu_cmd_sequencer.
// slave = the sequencer itself, master = whatever sits around it (producer, ALU, consumer).
interface alu_cmd_sequencer_if;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [2:0]  CMD_OP;
  logic [15:0] CMD_X;
  logic [15:0] CMD_Y;
  logic        ALU_EN;
  logic [2:0]  ALU_OP;
  logic [15:0] ALU_X;
  logic [15:0] ALU_Y;
  logic [15:0] ALU_RES;
  logic        ALU_CF;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [15:0] RSP_DATA;
  logic        RSP_CF;
  logic        BUSY;

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_X, CMD_Y, ALU_RES, ALU_CF, RSP_READY,
    output CMD_READY, ALU_EN, ALU_OP, ALU_X, ALU_Y, RSP_VALID, RSP_DATA, RSP_CF, BUSY
  );

  modport master (
    output CMD_VALID, CMD_OP, CMD_X, CMD_Y, ALU_RES, ALU_CF, RSP_READY,
    input  CMD_READY, ALU_EN, ALU_OP, ALU_X, ALU_Y, RSP_VALID, RSP_DATA, RSP_CF, BUSY
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands in a FIFO, issues one at a time, waits ALU_LAT, returns a response.
// Optional ALU_CMD_SEQ_STATS_EN adds saturating STAT_OPS / STAT_CF counters.
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  alu_cmd_sequencer_if.slave   io
`ifdef ALU_CMD_SEQ_STATS_EN
  ,
  output logic [15:0]          STAT_OPS,
  output logic [15:0]          STAT_CF
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = $clog2(ALU_LAT + 1);

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] x;
    logic [15:0] y;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q, count_d;
  logic          cmd_ready_q;
  logic          push, pop, issue, capture, rsp_done;
  logic [LW-1:0] cnt_q;

  logic          alu_en_q;
  logic [2:0]    alu_op_q;
  logic [15:0]   alu_x_q, alu_y_q;
  logic          rsp_valid_q;
  logic [15:0]   rsp_data_q;
  logic          rsp_cf_q;

  assign head    = mem[rd_ptr];
  assign push    = io.CMD_VALID && cmd_ready_q;
  assign count_d = count_q + CW'(push) - CW'(pop);

  // FSM next-state and one-cycle control strobes
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    issue    = 1'b0;
    capture  = 1'b0;
    rsp_done = 1'b0;
    case (state_q)
      IDLE: if (count_q != '0) begin
        pop = 1'b1;
        if (head.op != 3'b000) begin
          issue   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: if (cnt_q == '0) begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: if (io.RSP_READY) begin
        rsp_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= '{op: io.CMD_OP, x: io.CMD_X, y: io.CMD_Y};
  end

  // READY comes from the post-update count, so a pop while full never admits a push
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count_q     <= count_d;
      cmd_ready_q <= (count_d != CW'(DEPTH));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      alu_en_q    <= 1'b0;
      alu_op_q    <= '0;
      alu_x_q     <= '0;
      alu_y_q     <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_cf_q    <= 1'b0;
    end else begin
      alu_en_q <= issue;
      if (issue) begin
        alu_op_q <= head.op;
        alu_x_q  <= head.x;
        alu_y_q  <= head.y;
        cnt_q    <= LW'(ALU_LAT);
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - LW'(1);
      end
      if (capture) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= io.ALU_RES;
        rsp_cf_q    <= io.ALU_CF;
      end else if (rsp_done) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

`ifdef ALU_CMD_SEQ_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      STAT_OPS <= '0;
      STAT_CF  <= '0;
    end else begin
      if (issue && STAT_OPS != 16'hFFFF)                  STAT_OPS <= STAT_OPS + 16'd1;
      if (capture && io.ALU_CF && STAT_CF != 16'hFFFF)    STAT_CF  <= STAT_CF + 16'd1;
    end
  end
`endif

  assign io.CMD_READY = cmd_ready_q;
  assign io.ALU_EN    = alu_en_q;
  assign io.ALU_OP    = alu_op_q;
  assign io.ALU_X     = alu_x_q;
  assign io.ALU_Y     = alu_y_q;
  assign io.RSP_VALID = rsp_valid_q;
  assign io.RSP_DATA  = rsp_data_q;
  assign io.RSP_CF    = rsp_cf_q;
  assign io.BUSY      = (state_q != IDLE) || (count_q != '0);

endmodule
